// File: rtl/ahb_multiplexor_n_if.sv
// ahb_multiplexor_n_if: bus signals between decoder, slaves, master and the response multiplexor
interface ahb_multiplexor_n_if #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4
);
    localparam int SEL_WIDTH = $clog2(SLAVE_DEVICES + 2);
    logic [1:0]                              ahb_trans_in;
    logic [SEL_WIDTH-1:0]                    decoder_sel_in;
    logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_rdata_in;
    logic [SLAVE_DEVICES-1:0]                slave_readyout_in;
    logic [SLAVE_DEVICES-1:0]                slave_resp_in;
    logic [AHB_DATA_WIDTH-1:0]               ahb_rdata_out;
    logic                                    ahb_ready_out;
    logic                                    ahb_resp_out;
    modport slave (
        input  ahb_trans_in, decoder_sel_in, slave_rdata_in, slave_readyout_in, slave_resp_in,
        output ahb_rdata_out, ahb_ready_out, ahb_resp_out
    );
    modport master (
        output ahb_trans_in, decoder_sel_in, slave_rdata_in, slave_readyout_in, slave_resp_in,
        input  ahb_rdata_out, ahb_ready_out, ahb_resp_out
    );
endinterface

// File: rtl/ahb_multiplexor_n.sv
// ahb_multiplexor_n: AHB slave-to-master response mux with default ERROR slave; AHB_MUX_ERR_COUNT_EN adds err_count_out
module ahb_multiplexor_n #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4
) (
    input  logic                 ahb_clk_in,
    input  logic                 ahb_rstn_in,
    ahb_multiplexor_n_if.slave   bus
`ifdef AHB_MUX_ERR_COUNT_EN
    ,
    output logic [15:0]          err_count_out
`endif
);
    localparam int SEL_WIDTH = $clog2(SLAVE_DEVICES + 2);
    localparam logic [SEL_WIDTH-1:0] SEL_MAX = SEL_WIDTH'(SLAVE_DEVICES + 1);
    localparam logic [SEL_WIDTH-1:0] SEL_DEF = SEL_WIDTH'(1);

    typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

    ds_state_t                 ds_state_q;
    logic                      ds_ready_q;
    logic                      ds_resp_q;
    logic [SEL_WIDTH-1:0]      dsel_q;
    logic [SEL_WIDTH-1:0]      dsel_d;
    logic [SEL_WIDTH-1:0]      sel_map;
    logic                      active;
    logic [AHB_DATA_WIDTH-1:0] rdata;
    logic                      ready;
    logic                      resp;

    assign sel_map = (bus.decoder_sel_in > SEL_MAX) ? SEL_DEF : bus.decoder_sel_in;
    assign active  = bus.ahb_trans_in[1];
    assign dsel_d  = ready ? sel_map : dsel_q;

    // Data-phase select only advances when the current data phase completes
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) dsel_q <= '0;
        else dsel_q <= dsel_d;
    end

    // Default slave: OKAY for idle accesses, two-cycle ERROR for active unmapped ones
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            ds_state_q <= DS_IDLE;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 1'b0;
        end else if (ds_state_q == DS_ERR1) begin
            ds_state_q <= DS_ERR2;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 1'b1;
        end else if (ready) begin
            ds_state_q <= (sel_map == SEL_DEF && active) ? DS_ERR1 : DS_IDLE;
            ds_ready_q <= !(sel_map == SEL_DEF && active);
            ds_resp_q  <= sel_map == SEL_DEF && active;
        end
    end

    // Route the data-phase owner's response to the master; unselected slaves never leak through
    always_comb begin
        rdata = '0;
        ready = 1'b1;
        resp  = 1'b0;
        if (dsel_q == SEL_DEF) begin
            ready = ds_ready_q;
            resp  = ds_resp_q;
        end
        for (int k = 0; k < SLAVE_DEVICES; k++) begin
            if (dsel_q == SEL_WIDTH'(k + 2)) begin
                rdata = bus.slave_rdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
                ready = bus.slave_readyout_in[k];
                resp  = bus.slave_resp_in[k];
            end
        end
    end

    assign bus.ahb_rdata_out = rdata;
    assign bus.ahb_ready_out = ready;
    assign bus.ahb_resp_out  = resp;

`ifdef AHB_MUX_ERR_COUNT_EN
    logic [15:0] err_q;

    // One count per completed ERROR response, saturating
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) err_q <= '0;
        else if (ready && resp && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end

    assign err_count_out = err_q;
`endif
endmodule
